// File: rtl/vga_scan_ctrl.sv
// VGA timing controller: halves CLOCK_50 into a pixel tick, walks H/V scan FSMs, requests one
// pixel per visible position and drives the DAC/sync pins with a fixed one-pixel-period latency.
module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_LOW = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       req_valid,
    output logic [9:0] req_x,
    output logic [9:0] req_y,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    typedef enum logic [1:0] {StAct, StFp, StSync, StBp} scan_state_e;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HEndAct  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] HEndFp   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] HEndSync = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] HEndTot  = 10'(H_TOTAL - 1);
    localparam logic [9:0] VEndAct  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] VEndFp   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] VEndSync = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] VEndTot  = 10'(V_TOTAL - 1);

    function automatic scan_state_e step(input scan_state_e st, input logic [9:0] cnt,
                                         input logic [9:0] e_act, input logic [9:0] e_fp,
                                         input logic [9:0] e_sync, input logic [9:0] e_tot);
        step = st;
        unique case (st)
            StAct:  if (cnt == e_act)  step = StFp;
            StFp:   if (cnt == e_fp)   step = StSync;
            StSync: if (cnt == e_sync) step = StBp;
            StBp:   if (cnt == e_tot)  step = StAct;
        endcase
    endfunction

    logic        tick_q, tick_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    scan_state_e h_st_q, h_st_d, v_st_q, v_st_d;
    logic        cap_q, cap_d;
    logic [23:0] hold_q, hold_d;
    logic        s1_act_q, s1_act_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic        blank_n_q, blank_n_d, hs_q, hs_d, vs_q, vs_d;
    logic [23:0] rgb_q, rgb_d;

    logic ptick, active, h_wrap;

    assign ptick  = enable & tick_q;
    assign active = (h_st_q == StAct) && (v_st_q == StAct);
    assign h_wrap = (h_cnt_q == HEndTot);

    assign req_valid   = ptick & active;
    assign req_x       = h_cnt_q;
    assign req_y       = v_cnt_q;
    assign frame_start = ptick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    always_comb begin
        tick_d    = ~tick_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        h_st_d    = h_st_q;
        v_st_d    = v_st_q;
        cap_d     = req_valid;
        hold_d    = hold_q;
        s1_act_d  = s1_act_q;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        blank_n_d = blank_n_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        rgb_d     = rgb_q;

        // Source answers in the non-tick cycle right after its request.
        if (cap_q) hold_d = {pix_r, pix_g, pix_b};

        if (ptick) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
            h_st_d  = step(h_st_q, h_cnt_q, HEndAct, HEndFp, HEndSync, HEndTot);
            if (h_wrap) begin
                v_cnt_d = (v_cnt_q == VEndTot) ? 10'd0 : v_cnt_q + 10'd1;
                v_st_d  = step(v_st_q, v_cnt_q, VEndAct, VEndFp, VEndSync, VEndTot);
            end
            // Position flags wait one pixel period so they leave with the fetched pixel.
            s1_act_d  = active;
            s1_hs_d   = (h_st_q == StSync);
            s1_vs_d   = (v_st_q == StSync);
            blank_n_d = s1_act_q;
            hs_d      = s1_hs_q ^ SYNC_LOW;
            vs_d      = s1_vs_q ^ SYNC_LOW;
            rgb_d     = s1_act_q ? hold_q : 24'd0;
        end

        if (!enable) begin
            tick_d    = 1'b0;
            h_cnt_d   = 10'd0;
            v_cnt_d   = 10'd0;
            h_st_d    = StAct;
            v_st_d    = StAct;
            cap_d     = 1'b0;
            hold_d    = 24'd0;
            s1_act_d  = 1'b0;
            s1_hs_d   = 1'b0;
            s1_vs_d   = 1'b0;
            blank_n_d = 1'b0;
            hs_d      = SYNC_LOW;
            vs_d      = SYNC_LOW;
            rgb_d     = 24'd0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            h_st_q    <= StAct;
            v_st_q    <= StAct;
            cap_q     <= 1'b0;
            hold_q    <= 24'd0;
            s1_act_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            blank_n_q <= 1'b0;
            hs_q      <= SYNC_LOW;
            vs_q      <= SYNC_LOW;
            rgb_q     <= 24'd0;
        end else begin
            tick_q    <= tick_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_st_q    <= h_st_d;
            v_st_q    <= v_st_d;
            cap_q     <= cap_d;
            hold_q    <= hold_d;
            s1_act_q  <= s1_act_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign VGA_CLK     = tick_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a shrunken raster: requests push expected pixels and
// pin timing, the output side pops and compares; sync/blank geometry is measured on the pins.
module tb_vga_scan_ctrl;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] pr, pg, pb;
    logic       req_valid, frame_start, vga_clk, hs, vs, blank_n, sync_n;
    logic [9:0] req_x, req_y;
    logic [7:0] vr, vg, vb;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .SYNC_LOW(1'b1)
    ) dut (
        .CLOCK_50(clk), .reset(rst), .enable(en),
        .pix_r(pr), .pix_g(pg), .pix_b(pb),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .frame_start(frame_start),
        .VGA_CLK(vga_clk), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
        .VGA_SYNC_N(sync_n), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb)
    );

    always #10 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_of(input logic [9:0] x, input logic [9:0] y);
        return {x[7:0], y[7:0], x[7:0] ^ y[7:0] ^ 8'h5a};
    endfunction

    logic [23:0] exp_q[$];
    int          due_q[$];
    int          cyc = 0, ex = 0, ey = 0, n_req_frame = 0;
    int          t_fs = -1, t_blank = -1, t_hs = -1, t_vs = -1;
    logic        prev_req = 0, en_prev = 0, clk_prev = 0;
    logic        blank_prev = 0, hs_prev = 1, vs_prev = 1;
    logic [9:0]  px = 0, py = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst || !en) begin
            if (!rst && !en_prev) begin
                check_eq("idle_blank", blank_n, 0);
                check_eq("idle_rgb", {vr, vg, vb}, 0);
                check_eq("idle_req", req_valid, 0);
                check_eq("idle_hs", hs, 1);
                check_eq("idle_clk", vga_clk, 0);
            end
            exp_q.delete();
            due_q.delete();
            ex = 0; ey = 0; n_req_frame = 0; prev_req = 0;
            t_fs = -1; t_blank = -1; t_hs = -1; t_vs = -1;
            blank_prev = 0; hs_prev = 1; vs_prev = 1; clk_prev = 0;
            {pr, pg, pb} = 24'($urandom);
            en_prev = 0;
        end else begin
            check_eq("vga_clk", vga_clk, en_prev ? !clk_prev : 1'b0);
            // Pixel source: valid data only in the cycle after a request.
            if (prev_req) {pr, pg, pb} = pix_of(px, py);
            else          {pr, pg, pb} = 24'($urandom);

            check_eq("frame_start", frame_start, req_valid && ex == 0 && ey == 0);
            if (frame_start) begin
                check_eq("sync_n", sync_n, 0);
                if (t_fs >= 0) begin
                    check_eq("fs_period", cyc - t_fs, 2 * HT * VT);
                    check_eq("req_per_frame", n_req_frame, HA * VA);
                end
                t_fs = cyc;
                n_req_frame = 0;
            end
            if (req_valid) begin
                check_eq("req_on_tick", vga_clk, 1);
                check_eq("req_gap", prev_req, 0);
                check_eq("req_x", req_x, ex);
                check_eq("req_y", req_y, ey);
                exp_q.push_back(pix_of(10'(ex), 10'(ey)));
                due_q.push_back(cyc + 3);
                n_req_frame++;
                ex++;
                if (ex == HA) begin
                    ex = 0;
                    ey = (ey == VA - 1) ? 0 : ey + 1;
                end
            end
            prev_req = req_valid;
            px = req_x;
            py = req_y;

            if (!vga_clk) begin
                if (blank_n) begin
                    if (exp_q.size() == 0) check_eq("out_queue", exp_q.size(), 1);
                    else begin
                        check_eq("rgb", {vr, vg, vb}, exp_q.pop_front());
                        check_eq("rgb_latency", cyc, due_q.pop_front());
                    end
                end else check_eq("rgb_blanked", {vr, vg, vb}, 0);
            end

            if (blank_n && !blank_prev) t_blank = cyc;
            if (!blank_n && blank_prev && t_blank >= 0)
                check_eq("blank_width", cyc - t_blank, 2 * HA);
            if (!hs && hs_prev) begin
                t_hs = cyc;
                if (t_blank >= 0 && cyc - t_blank < 2 * HT)
                    check_eq("hs_offset", cyc - t_blank, 2 * (HA + HF));
            end
            if (hs && !hs_prev && t_hs >= 0) check_eq("hs_width", cyc - t_hs, 2 * HSW);
            if (!vs && vs_prev) begin
                t_vs = cyc;
                if (t_fs >= 0) check_eq("vs_offset", cyc - t_fs, 2 * (VA + VF) * HT + 3);
            end
            if (vs && !vs_prev && t_vs >= 0) check_eq("vs_width", cyc - t_vs, 2 * VSW * HT);

            blank_prev = blank_n;
            hs_prev    = hs;
            vs_prev    = vs;
            clk_prev   = vga_clk;
            en_prev    = 1;
        end
    end

    task automatic check_reset_pins(input string tag);
        check_eq({tag, "_req_valid"}, req_valid, 0);
        check_eq({tag, "_frame_start"}, frame_start, 0);
        check_eq({tag, "_req_xy"}, {req_x, req_y}, 0);
        check_eq({tag, "_vga_clk"}, vga_clk, 0);
        check_eq({tag, "_hs_vs"}, {hs, vs}, 2'b11);
        check_eq({tag, "_blank_n"}, blank_n, 0);
        check_eq({tag, "_rgb"}, {vr, vg, vb}, 0);
    endtask

    task automatic wait_req(input string tag, input int x, input int y, input int budget);
        int   n = 0;
        logic found = 0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            found = req_valid && req_x == 10'(x) && req_y == 10'(y);
        end
        check_eq(tag, found, 1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        {pr, pg, pb} = 24'd0;
        repeat (3) @(posedge clk);
        #1 check_reset_pins("reset");
        rst = 1'b0;

        // Free-running frames: geometry, scoreboard, frame period.
        repeat (620) @(negedge clk);

        // Drop enable mid-frame, hold it low, then restart from the origin.
        wait_req("wait_drop_pos", 5, 2, 600);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (100) @(posedge clk);
        #1 en = 1'b1;
        wait_req("restart_origin", 0, 0, 4);
        repeat (520) @(negedge clk);

        // Asynchronous reset mid-line.
        wait_req("wait_reset_pos", 4, 1, 600);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_pins("async_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_req("reset_origin", 0, 0, 4);
        repeat (520) @(negedge clk);

        // Finish in vertical sync, when every requested pixel has left the pipe.
        begin
            int n = 0;
            while (vs && n < 2 * HT * VT) begin
                @(negedge clk);
                n++;
            end
            check_eq("final_vs_reached", vs, 0);
        end
        check_eq("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
